fir_interp2: RTL and testbench

2x polyphase interpolating FIR for the audio output path, the upsampling counterpart to the anti-aliasing low-pass FIR on the input side. Accepts signed 16-bit samples over a valid/ready handshake and emits two filtered samples per input (phase 0, then phase 1) over a second valid/ready handshake. A single time-multiplexed multiply-accumulate unit computes all taps, so the block trades cycles for area. It sits between the audio mixer and the output DAC/resampler stage.

---
 rtl/fir_interp_pkg.sv | 43 ++++
 rtl/fir_interp2_mac.sv | 45 ++++
 rtl/fir_interp2.sv | 143 ++++++++++++++
 tb/tb_fir_interp2.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared types, widths and the fixed 16-tap prototype for the 2x polyphase interpolator.
// Prototype taps are interleaved: phase p uses H[2k+p] against delay-line slot k.
package fir_interp_pkg;

  localparam int DATA_W         = 16;
  localparam int COEF_W         = 16;
  localparam int TAPS_PER_PHASE = 8;
  localparam int ACC_W          = 36;
  localparam int FRAC_W         = 15;
  localparam int TAP_W          = $clog2(TAPS_PER_PHASE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC0,
    ST_RND0,
    ST_OUT0,
    ST_MAC1,
    ST_RND1,
    ST_OUT1
  } state_t;

  // Each phase (even taps, odd taps) sums to exactly 32768 for unity DC gain.
  localparam logic signed [COEF_W-1:0] H [2*TAPS_PER_PHASE] = '{
    -16'sd316,  -16'sd200,   16'sd1200,   16'sd800,
    -16'sd3000, -16'sd2600,  16'sd18500,  16'sd18384,
     16'sd18500, 16'sd18384, -16'sd3000, -16'sd2600,
     16'sd1200,  16'sd800,   -16'sd316,  -16'sd200
  };

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 <<< (FRAC_W - 1));

  function automatic logic signed [COEF_W-1:0] coef_phase(input logic p,
                                                           input logic [TAP_W-1:0] k);
    return H[{k, p}];
  endfunction

  function automatic logic signed [ACC_W-1:0] round_q15(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] biased;
    biased = acc + RND_HALF;
    return biased >>> FRAC_W;
  endfunction

endpackage

// File: rtl/fir_interp2_mac.sv
// Single signed multiply-accumulate unit shared by every tap of both phases.
// clr has priority over en so a new sample always starts from an empty accumulator.
module fir_mac #(
  parameter int A_W   = fir_interp_pkg::DATA_W,
  parameter int B_W   = fir_interp_pkg::COEF_W,
  parameter int ACC_W = fir_interp_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  import fir_interp_pkg::*;

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;

  always_comb begin
    prod     = a * b;
    prod_ext = {{(ACC_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_interp2.sv
// 2x polyphase interpolating FIR: one input sample yields a phase-0 then a phase-1 output.
// Define FIR_INTERP_SAT_EN to clamp rounded results; otherwise they wrap to DATA_W bits.
module fir_interp2 #(
  parameter int DATA_W         = fir_interp_pkg::DATA_W,
  parameter int COEF_W         = fir_interp_pkg::COEF_W,
  parameter int TAPS_PER_PHASE = fir_interp_pkg::TAPS_PER_PHASE,
  parameter int ACC_W          = fir_interp_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  import fir_interp_pkg::*;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS_PER_PHASE - 1);

  state_t                   state_d, state_q;
  logic [TAP_W-1:0]         tap_d, tap_q;
  logic signed [DATA_W-1:0] x_d [TAPS_PER_PHASE];
  logic signed [DATA_W-1:0] x_q [TAPS_PER_PHASE];
  logic [DATA_W-1:0]        out_data_d, out_data_q;
  logic [DATA_W-1:0]        result;
  logic                     mac_clr;
  logic                     mac_en;
  logic                     phase;
  logic signed [COEF_W-1:0] coef;
  logic signed [ACC_W-1:0]  acc;

  assign phase = (state_q == ST_MAC1);
  assign coef  = coef_phase(phase, tap_q);

  fir_mac #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (x_q[tap_q]),
    .b       (coef),
    .acc     (acc)
  );

`ifdef FIR_INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    rounded = round_q15(acc);
    if (rounded > SAT_MAX) begin
      result = DATA_W'(SAT_MAX);
    end else if (rounded < SAT_MIN) begin
      result = DATA_W'(SAT_MIN);
    end else begin
      result = rounded[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    result = DATA_W'(round_q15(acc));
  end
`endif

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mac_clr = 1'b1;
          tap_d   = '0;
          for (int i = TAPS_PER_PHASE - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = in_data;
          state_d = ST_MAC0;
        end
      end
      ST_MAC0, ST_MAC1: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d = (state_q == ST_MAC0) ? ST_RND0 : ST_RND1;
        end
      end
      ST_RND0, ST_RND1: begin
        out_data_d = result;
        state_d    = (state_q == ST_RND0) ? ST_OUT0 : ST_OUT1;
      end
      ST_OUT0: begin
        if (out_ready) begin
          mac_clr = 1'b1;
          tap_d   = '0;
          state_d = ST_MAC1;
        end
      end
      ST_OUT1: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      out_data_q <= '0;
      for (int i = 0; i < TAPS_PER_PHASE; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      out_data_q <= out_data_d;
      x_q        <= x_d;
    end
  end

  // Handshake flags come straight from the state register so neither side sees a combinational path.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT0) || (state_q == ST_OUT1);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_interp2.sv
// Self-checking bench for fir_interp2 against a direct-form interpolation model.
// Build with FIR_INTERP_SAT_EN defined to check the clamping variant.
module tb_fir_interp2;

  import fir_interp_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;
  int hist [8];

  fir_interp2 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: y_p = sum_k h[2k+p] * x[k], rounded half-up at Q15, then clamped or wrapped.
  function automatic logic signed [15:0] model_out(input int p);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc += longint'(H[2*k+p]) * longint'(hist[k]);
    end
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_INTERP_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic push(input logic signed [15:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(v);
  endtask

  // Waits for out_valid, checks the sample, then hands it off; lat counts cycles since the prior handshake.
  task automatic pop(input int p, input string tag, output int lat, output logic signed [15:0] obs);
    logic signed [15:0] exp_v;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    exp_v = model_out(p);
    obs   = out_data;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL %s_timeout: out_valid=%0b required 1", tag, out_valid);
    end else if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s_p%0d: out_data=%0d required %0d", tag, p, $signed(obs), exp_v);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    logic signed [15:0] obs;
    #1;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %0b required 0", out_valid); end
    if (out_data !== 16'd0) begin errors++; $display("[TB] FAIL rst_out_data: got %0d required 0", out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    push(16'sd12000);
    pop(0, "rst_pre", lat, obs);
    pop(1, "rst_pre", lat, obs);
    push(16'($urandom));
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid: got %0b required 0", out_valid); end
    if (out_data !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_out_data: got %0d required 0", out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    push(16'($urandom));
    pop(0, "rst_post", lat, obs);
    pop(1, "rst_post", lat, obs);
  endtask

  task automatic test_latency();
    int lat;
    logic signed [15:0] obs;
    push(16'($urandom));
    pop(0, "lat", lat, obs);
    checks++;
    if (lat !== 10) begin errors++; $display("[TB] FAIL lat_phase0: got %0d cycles required 10", lat); end
    pop(1, "lat", lat, obs);
    checks++;
    if (lat !== 10) begin errors++; $display("[TB] FAIL lat_phase1: got %0d cycles required 10", lat); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_out1: got %0b required 1", in_ready); end
  endtask

  task automatic test_dc();
    int lat;
    logic signed [15:0] obs;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      push(16'sd1000);
      for (int p = 0; p < 2; p++) begin
        pop(p, "dc", lat, obs);
        if (i >= 7) begin
          checks++;
          if (obs !== 16'sd1000) begin
            errors++;
            $display("[TB] FAIL dc_gain: in#%0d p%0d got %0d required 1000", i, p, obs);
          end
        end
      end
    end
  endtask

  task automatic test_impulse();
    int lat;
    int e;
    logic signed [15:0] obs;
    logic signed [15:0] ev;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      push((i == 0) ? 16'sd16384 : 16'sd0);
      for (int p = 0; p < 2; p++) begin
        pop(p, "imp", lat, obs);
        e  = (int'(H[2*i+p]) + 1) >>> 1;
        ev = 16'(e);
        checks++;
        if (obs !== ev) begin
          errors++;
          $display("[TB] FAIL impulse_h%0d: got %0d required %0d", 2*i+p, obs, ev);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [15:0] obs;
    logic signed [15:0] e0;
    push(16'($urandom));
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    e0 = model_out(0);
    for (int i = 0; i < 20; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: cyc %0d got %0b required 1", i, out_valid); end
      if (out_data !== e0) begin errors++; $display("[TB] FAIL bp_data: cyc %0d got %0d required %0d", i, $signed(out_data), e0); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: cyc %0d got %0b required 0", i, in_ready); end
      in_valid = i[0];
      in_data  = 16'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    pop(1, "bp_resume", lat, obs);
  endtask

  task automatic test_random();
    int lat;
    logic signed [15:0] obs;
    for (int i = 0; i < 16; i++) begin
      push(16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pop(0, "rand", lat, obs);
      pop(1, "rand", lat, obs);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic signed [15:0] obs;
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      for (int j = 0; j < 8; j++) begin
        if ((H[2*(7-j)] >= 0) == (s == 0)) push(16'sd32767);
        else push(-16'sd32768);
        pop(0, "sat", lat, obs);
`ifdef FIR_INTERP_SAT_EN
        if (j == 7) begin
          checks++;
          if (obs !== ((s == 0) ? 16'sd32767 : -16'sd32768)) begin
            errors++;
            $display("[TB] FAIL sat_clamp_s%0d: got %0d required %0d", s, obs,
                     (s == 0) ? 32767 : -32768);
          end
        end
`endif
        pop(1, "sat", lat, obs);
      end
    end
  endtask

  task automatic test_reset_mac1();
    int lat;
    logic signed [15:0] obs;
    push(16'($urandom));
    pop(0, "rm1", lat, obs);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm1_in_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm1_out_valid: got %0b required 0", out_valid); end
    if (out_data !== 16'd0) begin errors++; $display("[TB] FAIL rm1_out_data: got %0d required 0", out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rm1_stale: cyc %0d out_valid=%0b in_ready=%0b required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_latency();
    test_dc();
    test_impulse();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_mac1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
